// File: rtl/mono_conf_drv.sv
// mono_conf_drv: configuration shift-register driver for a pixel chip.
// A byte-addressable stream buffer is filled over the CFG_* port. On START
// the first SIZE bits (MSB-first per byte) are shifted out on SR_In. Each
// bit takes one low phase and one high phase of Clk_Conf. An optional
// LdDAC/LdPix load strobe follows the shift. RST_REQ instead produces a
// 4-cycle SR_RST pulse. DONE pulses for one cycle at the end of either
// operation.
//
// Ports
//   Clk, nRST                   system clock, async active-low reset
//   CFG_WR/CFG_ADDR/CFG_WDATA   buffer byte write (ignored while BUSY)
//   CFG_RDATA                   buffer byte at CFG_ADDR, one cycle latency
//   START/SIZE/LOAD_SEL         shift request, bit count, load strobe select
//   RST_REQ                     chip SR reset request (accepted in IDLE only)
//   BUSY, DONE                  status
//   Clk_Conf, SR_In, SR_EN,
//   LdDAC, LdPix, SR_RST        chip configuration pins
//   SR_out                      chip SR readback
//
// Build option: MONO_CONF_READBACK_EN. When it is defined, SR_out is sampled
// at the end of each SHIFT_LO and written back over the bit just sent, so the
// buffer ends up holding the chip's previous contents.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for START or RST_REQ
// SHIFT_LO  | Clk_Conf low, SR_In presents bit idx
// SHIFT_HI  | Clk_Conf high, SR_In held, chip captures bit
// LOAD      | 2 cycles of LdDAC/LdPix per latched LOAD_SEL
// RST_PULSE | 4 cycles of SR_RST
// FIN       | DONE pulse, back to IDLE

module mono_conf_drv #(
  parameter int MEM_BYTES = 512
) (
  input  logic        Clk,
  input  logic        nRST,
  input  logic        CFG_WR,
  input  logic [8:0]  CFG_ADDR,
  input  logic [7:0]  CFG_WDATA,
  output logic [7:0]  CFG_RDATA,
  input  logic        START,
  input  logic [12:0] SIZE,
  input  logic [1:0]  LOAD_SEL,
  input  logic        RST_REQ,
  output logic        BUSY,
  output logic        DONE,
  output logic        Clk_Conf,
  output logic        SR_In,
  output logic        SR_EN,
  output logic        LdDAC,
  output logic        LdPix,
  output logic        SR_RST,
  input  logic        SR_out
);

  localparam logic [12:0] MAX_BITS = 13'(MEM_BYTES * 8);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, RST_PULSE, FIN} state_t;

  state_t      state, state_nxt;
  logic [12:0] size_q, size_nxt;
  logic [12:0] idx_q, idx_nxt;
  logic [1:0]  sel_q, sel_nxt;
  logic [1:0]  cnt_q, cnt_nxt;
  logic        bit_q, bit_nxt;

  logic [7:0]  mem [MEM_BYTES];
  logic [12:0] size_clip;
  logic [11:0] rd_idx;
  logic        rd_bit;

  assign size_clip = (SIZE > MAX_BITS) ? MAX_BITS : SIZE;

  // Index of the bit that will be presented in the next SHIFT_LO. It is
  // latched into bit_q so SR_In stays stable even if readback rewrites it.
  assign rd_idx = (state == IDLE) ? 12'd0 : (idx_q[11:0] + 12'd1);
  assign rd_bit = mem[rd_idx[11:3]][~rd_idx[2:0]];

  always_ff @(posedge Clk or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      size_q <= '0;
      idx_q  <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
      bit_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      size_q <= size_nxt;
      idx_q  <= idx_nxt;
      sel_q  <= sel_nxt;
      cnt_q  <= cnt_nxt;
      bit_q  <= bit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    size_nxt  = size_q;
    idx_nxt   = idx_q;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt_q;
    bit_nxt   = bit_q;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    Clk_Conf  = 1'b0;
    SR_In     = 1'b0;
    SR_EN     = 1'b0;
    LdDAC     = 1'b0;
    LdPix     = 1'b0;
    SR_RST    = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          size_nxt = size_clip;
          sel_nxt  = LOAD_SEL;
          idx_nxt  = '0;
          bit_nxt  = rd_bit;
          cnt_nxt  = 2'd1;
          if (size_clip != 13'd0)   state_nxt = SHIFT_LO;
          else if (LOAD_SEL != 2'b00) state_nxt = LOAD;
          else                      state_nxt = FIN;
        end else if (RST_REQ) begin
          cnt_nxt   = 2'd3;
          state_nxt = RST_PULSE;
        end
      end
      SHIFT_LO: begin
        BUSY      = 1'b1;
        SR_EN     = 1'b1;
        SR_In     = bit_q;
        state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        BUSY     = 1'b1;
        SR_EN    = 1'b1;
        SR_In    = bit_q;
        Clk_Conf = 1'b1;
        if (idx_q == size_q - 13'd1) begin
          cnt_nxt   = 2'd1;
          state_nxt = (sel_q != 2'b00) ? LOAD : FIN;
        end else begin
          idx_nxt   = idx_q + 13'd1;
          bit_nxt   = rd_bit;
          state_nxt = SHIFT_LO;
        end
      end
      LOAD: begin
        BUSY  = 1'b1;
        LdDAC = sel_q[0];
        LdPix = sel_q[1];
        if (cnt_q == 2'd0) state_nxt = FIN;
        else               cnt_nxt   = cnt_q - 2'd1;
      end
      RST_PULSE: begin
        BUSY   = 1'b1;
        SR_RST = 1'b1;
        if (cnt_q == 2'd0) state_nxt = FIN;
        else               cnt_nxt   = cnt_q - 2'd1;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer contents survive reset, so this array has no reset branch.
  always_ff @(posedge Clk) begin
    if (CFG_WR && !BUSY) begin
      mem[CFG_ADDR] <= CFG_WDATA;
    end
`ifdef MONO_CONF_READBACK_EN
    else if (state == SHIFT_LO) begin
      mem[idx_q[11:3]][~idx_q[2:0]] <= SR_out;
    end
`endif
  end

`ifndef MONO_CONF_READBACK_EN
  logic unused_sr_out;
  assign unused_sr_out = SR_out;
`endif

  always_ff @(posedge Clk or negedge nRST) begin
    if (!nRST) CFG_RDATA <= '0;
    else       CFG_RDATA <= mem[CFG_ADDR];
  end

endmodule

// File: doc/mono_conf_drv.md
MONO_CONF_DRV -- requirements
Module: mono_conf_drv

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512, meaning the size of the bit-stream buffer in bytes (4096 bits).
REQ-002 SHALL have port Clk  in  1  system clock; one clock domain; all state advances on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports CFG_WR in 1, CFG_ADDR in 9 and CFG_WDATA in 8, forming the byte write port into the stream buffer.
REQ-005 SHALL have port CFG_RDATA  out  8  buffer byte at CFG_ADDR, registered with 1-cycle latency.
REQ-006 SHALL have ports START in 1 (single-cycle request), SIZE in 13 (bits to shift) and LOAD_SEL in 2 (bit0 drives LdDAC, bit1 drives LdPix).
REQ-007 SHALL have port RST_REQ  in  1  single-cycle request for a chip SR reset pulse.
REQ-008 SHALL have ports BUSY out 1 and DONE out 1, where DONE is a one-cycle completion pulse.
REQ-009 SHALL have ports Clk_Conf, SR_In, SR_EN, LdDAC, LdPix and SR_RST, each out 1, driving the chip configuration pins.
REQ-010 SHALL have port SR_out  in  1  chip shift-register readback.

Function
REQ-011 SHALL be an FSM with states IDLE, SHIFT_LO, SHIFT_HI, LOAD, RST_PULSE and FIN.
REQ-012 SHALL accept START only in IDLE; START while BUSY SHALL be ignored; RST_REQ outside IDLE SHALL be ignored; START SHALL take priority over a simultaneous RST_REQ.
REQ-013 SHALL latch SIZE and LOAD_SEL on START; SIZE>4096 SHALL be clipped to 4096.
REQ-014 SHALL assert BUSY from the cycle after START until FIN; BUSY SHALL be low in the DONE cycle.
REQ-015 SHALL stream bits MSB-first: bit k = byte k/8, bit 7-(k mod 8), for k=0..SIZE-1.
REQ-016 SHALL, per bit, spend one SHIFT_LO cycle (Clk_Conf=0, SR_In=bit k) followed by one SHIFT_HI cycle (Clk_Conf=1, SR_In held), so that one bit takes 2 Clk cycles.
REQ-017 SHALL hold SR_EN high in SHIFT_LO and SHIFT_HI, and low otherwise.
REQ-018 SHALL, after the last bit, enter LOAD for 2 cycles if LOAD_SEL!=0, driving LdDAC=LOAD_SEL[0] and LdPix=LOAD_SEL[1]; otherwise it SHALL go directly to FIN.
REQ-019 SHALL treat SIZE=0 as zero shift cycles: START goes directly to LOAD or FIN, and Clk_Conf does not toggle.
REQ-020 SHALL pulse DONE high for exactly 1 cycle in FIN and then return to IDLE.
REQ-021 SHALL, on RST_REQ in IDLE, assert SR_RST for 4 cycles in RST_PULSE with BUSY high, then go to FIN.
REQ-022 SHALL ignore CFG_WR while BUSY; reads SHALL remain permitted.
REQ-023 SHALL give START-to-DONE latency of 2*SIZE + 2*(LOAD_SEL!=0) + 1 cycles.

Reset
REQ-024 SHALL on nRST low immediately force the FSM to IDLE and drive Clk_Conf=0, SR_In=0, SR_EN=0, LdDAC=0, LdPix=0, SR_RST=0, BUSY=0, DONE=0, CFG_RDATA=0.
REQ-025 SHALL NOT clear buffer contents on reset; a reset mid-shift SHALL abort without a DONE pulse.

Configuration
REQ-026 SHALL implement macro MONO_CONF_READBACK_EN.
REQ-027 SHALL, with MONO_CONF_READBACK_EN defined, sample SR_out at the edge ending each SHIFT_LO and overwrite buffer bit k with it; CFG_RDATA then returns chip readback.
REQ-028 SHALL, without MONO_CONF_READBACK_EN, leave the buffer unmodified by shifting, ignore SR_out, and have CFG_RDATA return the written data.

Verification
REQ-029 SHALL cover this scenario: write byte0=0xA5, SIZE=8, LOAD_SEL=0, START -> SR_In sequence 1,0,1,0,0,1,0,1 on 8 Clk_Conf rises; DONE at cycle 17; BUSY cycles 1..16.
REQ-030 SHALL cover this scenario: SIZE=3, LOAD_SEL=2'b10 -> LdPix high 2 cycles after the 3rd rise, LdDAC stays 0, DONE at cycle 9.
REQ-031 SHALL cover this scenario: SIZE=0, LOAD_SEL=0 -> no Clk_Conf edge, DONE at cycle 1.
REQ-032 SHALL cover this scenario: START repeated while BUSY, and SIZE=5000 -> the second START is ignored; exactly 4096 Clk_Conf rises occur.
REQ-033 SHALL cover this scenario: nRST low at bit 10 of 64 -> all outputs 0 immediately; no DONE pulse; the next START runs normally.
REQ-034 SHALL cover this scenario: with MONO_CONF_READBACK_EN, SR_out looped to a 16-bit chip SR preloaded with 0x1234 and SIZE=16 -> buffer bytes 0,1 read back 0x12,0x34.
